// File: rtl/quadrature_encoder_gen_if.sv
// ============================================================================
// Module      : quadrature_encoder_gen_if
// Description : Step-request / quadrature-output bundle for quadrature_encoder_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface quadrature_encoder_gen_if #(
   parameter int PENDING_W = 8
);
   logic                 step_cw;
   logic                 step_ccw;
   logic                 enable;
   logic                 clear;
   logic                 enc_a;
   logic                 enc_b;
   logic                 enc_z;
   logic                 busy;
   logic [PENDING_W-1:0] pending;
   logic                 overflow;

   modport master (
      output step_cw, step_ccw, enable, clear,
      input  enc_a, enc_b, enc_z, busy, pending, overflow
   );

   modport slave (
      input  step_cw, step_ccw, enable, clear,
      output enc_a, enc_b, enc_z, busy, pending, overflow
   );
endinterface

`default_nettype wire

// File: rtl/quadrature_encoder_gen.sv
// ============================================================================
// Module      : quadrature_encoder_gen
// Description : Step requests -> Gray-code A/B with programmable dwell per phase.
//               Optional index pulse enabled by defining INDEX_PULSE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module quadrature_encoder_gen #(
   parameter int PHASE_CYCLES   = 1000,
   parameter int PENDING_W      = 8,
   parameter int COUNTS_PER_REV = 24
) (
   input  wire logic               clk,
   input  wire logic               rst,
   quadrature_encoder_gen_if.slave bus
);
   localparam int TIMER_W = $clog2(PHASE_CYCLES + 1);
   localparam int EXT_W   = PENDING_W + 2;
   localparam logic [TIMER_W-1:0]      TIMER_RELOAD = TIMER_W'(PHASE_CYCLES - 1);
   localparam logic signed [EXT_W-1:0] P_ONE        = EXT_W'(1);
   localparam logic signed [EXT_W-1:0] M_ONE        = '1;
   localparam logic signed [EXT_W-1:0] SAT_MAX      = EXT_W'((2 ** (PENDING_W - 1)) - 1);
   localparam logic signed [EXT_W-1:0] SAT_MIN      = -SAT_MAX;

   if (PHASE_CYCLES < 1) begin : g_bad_phase
      $error("PHASE_CYCLES must be >= 1");
   end
   if (COUNTS_PER_REV < 1) begin : g_bad_rev
      $error("COUNTS_PER_REV must be >= 1");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_PH1  = 2'd1,
      S_PH2  = 2'd2
   } state_t;

   state_t               state_q,    state_d;
   logic [TIMER_W-1:0]   timer_q,    timer_d;
   logic [PENDING_W-1:0] pending_q,  pending_d;
   logic                 enc_a_q,    enc_a_d;
   logic                 enc_b_q,    enc_b_d;
   logic                 enc_z_q,    enc_z_d;
   logic                 dir_cw_q,   dir_cw_d;
   logic                 busy_q,     busy_d;
   logic                 overflow_q, overflow_d;

   logic                 start_step;
   logic signed [EXT_W-1:0] req_delta;
   logic signed [EXT_W-1:0] deq_delta;
   logic signed [EXT_W-1:0] pend_sum;

`ifdef INDEX_PULSE_EN
   localparam int POS_W = (COUNTS_PER_REV > 1) ? $clog2(COUNTS_PER_REV) : 1;
   localparam logic [POS_W-1:0] POS_LAST = POS_W'(COUNTS_PER_REV - 1);
   logic [POS_W-1:0] position_q, position_d;
`endif

   // Pending counter: request delta and dequeue are folded into one saturating sum.
   always_comb begin
      req_delta  = '0;
      deq_delta  = '0;
      start_step = 1'b0;
      if (bus.step_cw && !bus.step_ccw) begin
         req_delta = P_ONE;
      end else if (bus.step_ccw && !bus.step_cw) begin
         req_delta = M_ONE;
      end
      if ((state_q == S_IDLE) && bus.enable && (pending_q != '0)) begin
         start_step = 1'b1;
         deq_delta  = pending_q[PENDING_W-1] ? P_ONE : M_ONE;
      end
      pend_sum   = {{2{pending_q[PENDING_W-1]}}, pending_q} + req_delta + deq_delta;
      pending_d  = pend_sum[PENDING_W-1:0];
      overflow_d = 1'b0;
      if (bus.clear) begin
         pending_d = '0;
      end else if (pend_sum > SAT_MAX) begin
         pending_d  = SAT_MAX[PENDING_W-1:0];
         overflow_d = 1'b1;
      end else if (pend_sum < SAT_MIN) begin
         pending_d  = SAT_MIN[PENDING_W-1:0];
         overflow_d = 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      enc_a_d  = enc_a_q;
      enc_b_d  = enc_b_q;
      enc_z_d  = enc_z_q;
      dir_cw_d = dir_cw_q;
`ifdef INDEX_PULSE_EN
      position_d = position_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start_step) begin
               dir_cw_d = !pending_q[PENDING_W-1];
               if (!pending_q[PENDING_W-1]) begin
                  enc_a_d = !enc_a_q;
               end else begin
                  enc_b_d = !enc_b_q;
               end
               timer_d = TIMER_RELOAD;
               state_d = S_PH1;
            end
         end
         S_PH1: begin
            if (timer_q != '0) begin
               timer_d = timer_q - TIMER_W'(1);
            end else begin
               if (dir_cw_q) begin
                  enc_b_d = !enc_b_q;
               end else begin
                  enc_a_d = !enc_a_q;
               end
               timer_d = TIMER_RELOAD;
               state_d = S_PH2;
`ifdef INDEX_PULSE_EN
               if (dir_cw_q) begin
                  position_d = (position_q == POS_LAST) ? '0 : position_q + POS_W'(1);
               end else begin
                  position_d = (position_q == '0) ? POS_LAST : position_q - POS_W'(1);
               end
               enc_z_d = (position_d == '0);
`endif
            end
         end
         S_PH2: begin
            if (timer_q != '0) begin
               timer_d = timer_q - TIMER_W'(1);
            end else begin
               enc_z_d = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
            enc_z_d = 1'b0;
         end
      endcase
      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         pending_q  <= '0;
         enc_a_q    <= 1'b0;
         enc_b_q    <= 1'b0;
         enc_z_q    <= 1'b0;
         dir_cw_q   <= 1'b0;
         busy_q     <= 1'b0;
         overflow_q <= 1'b0;
`ifdef INDEX_PULSE_EN
         position_q <= '0;
`endif
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         pending_q  <= pending_d;
         enc_a_q    <= enc_a_d;
         enc_b_q    <= enc_b_d;
         enc_z_q    <= enc_z_d;
         dir_cw_q   <= dir_cw_d;
         busy_q     <= busy_d;
         overflow_q <= overflow_d;
`ifdef INDEX_PULSE_EN
         position_q <= position_d;
`endif
      end
   end

   assign bus.enc_a    = enc_a_q;
   assign bus.enc_b    = enc_b_q;
`ifdef INDEX_PULSE_EN
   assign bus.enc_z    = enc_z_q;
`else
   assign bus.enc_z    = 1'b0;
`endif
   assign bus.busy     = busy_q;
   assign bus.pending  = pending_q;
   assign bus.overflow = overflow_q;

endmodule

`default_nettype wire
